// File: rtl/sparse_ram_pkg.sv
// Shared definitions for the compressed sparse RAM writer and reader:
// FSM state type and bitwidth-dependent element geometry.
package sparse_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HEADER = 2'd3
  } pack_state_e;

  // Bitwidth code 3 is not a distinct width; it aliases the widest (code 2).
  function automatic logic [1:0] norm_bw(input logic [1:0] bw);
    return (bw == 2'd3) ? 2'd2 : bw;
  endfunction

  function automatic int elem_width(input logic [1:0] bw, input int sew);
    return sew << norm_bw(bw);
  endfunction

  function automatic int elems_per_word(input logic [1:0] bw, input int rp, input int sew);
    return (rp * sew) / elem_width(bw, sew);
  endfunction

endpackage

// File: rtl/ram_word_assembler.sv
// Slot-insert accumulator for one RAM data word plus the write register that
// presents a completed word to the RAM for exactly one cycle.
module ram_word_assembler
  import sparse_ram_pkg::*;
#(
  parameter int RAM_ADDRESS_WIDTH      = 14,
  parameter int RAM_PARALLEL           = 16,
  parameter int INDEX_WIDTH            = 4,
  parameter int SMALLEST_ELEMENT_WIDTH = 2
) (
  input  logic                                           clk,
  input  logic                                           reset_n,
  input  logic [1:0]                                     bw_i,
  input  logic                                           insert_i,
  input  logic [$clog2(RAM_PARALLEL)-1:0]                slot_i,
  input  logic [4*SMALLEST_ELEMENT_WIDTH-1:0]            value_i,
  input  logic [INDEX_WIDTH-1:0]                         index_i,
  input  logic                                           flush_i,
  input  logic                                           clear_i,
  input  logic [RAM_ADDRESS_WIDTH-1:0]                   addr_i,
  output logic                                           wr_valid_o,
  output logic [RAM_ADDRESS_WIDTH-1:0]                   wr_addr_o,
  output logic [RAM_PARALLEL*SMALLEST_ELEMENT_WIDTH-1:0] wr_value_o,
  output logic [RAM_PARALLEL*INDEX_WIDTH-1:0]            wr_index_o
);

  localparam int VW = RAM_PARALLEL * SMALLEST_ELEMENT_WIDTH;
  localparam int XW = RAM_PARALLEL * INDEX_WIDTH;

  logic [VW-1:0]                acc_val_q, acc_val_d, ins_val;
  logic [XW-1:0]                acc_idx_q, acc_idx_d, ins_idx;
  logic                         wr_valid_q;
  logic [RAM_ADDRESS_WIDTH-1:0] wr_addr_q;
  logic [VW-1:0]                wr_val_q;
  logic [XW-1:0]                wr_idx_q;
  int                           ew;

  // Slots are zero until written, so OR-ing the shifted element is an insert.
  always_comb begin
    ew        = elem_width(bw_i, SMALLEST_ELEMENT_WIDTH);
    ins_val   = (VW'(value_i) & ((VW'(1) << ew) - VW'(1))) << (int'(slot_i) * ew);
    ins_idx   = XW'(index_i) << (int'(slot_i) * INDEX_WIDTH);
    acc_val_d = acc_val_q;
    acc_idx_d = acc_idx_q;
    if (insert_i) begin
      acc_val_d = acc_val_q | ins_val;
      acc_idx_d = acc_idx_q | ins_idx;
    end
  end

  // A flush captures the accumulator including any element inserted this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_val_q  <= '0;
      acc_idx_q  <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_val_q   <= '0;
      wr_idx_q   <= '0;
    end else begin
      wr_valid_q <= flush_i;
      if (flush_i) begin
        wr_addr_q <= addr_i;
        wr_val_q  <= acc_val_d;
        wr_idx_q  <= acc_idx_d;
      end
      if (flush_i || clear_i) begin
        acc_val_q <= '0;
        acc_idx_q <= '0;
      end else begin
        acc_val_q <= acc_val_d;
        acc_idx_q <= acc_idx_d;
      end
    end
  end

  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_value_o = wr_val_q;
  assign wr_index_o = wr_idx_q;

endmodule

// File: rtl/ram_packer.sv
// Packs a stream of nonzero (value, index) pairs into sparse RAM words at
// addresses 1..N, then writes the element count header at address 0.
module ram_packer
  import sparse_ram_pkg::*;
#(
  parameter int RAM_ADDRESS_WIDTH      = 14,
  parameter int RAM_PARALLEL           = 16,
  parameter int INDEX_WIDTH            = 4,
  parameter int SMALLEST_ELEMENT_WIDTH = 2
) (
  input  logic                                           clk,
  input  logic                                           reset_n,
  input  logic [1:0]                                     bitwidth,
  input  logic                                           start,
  input  logic                                           finish,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [4*SMALLEST_ELEMENT_WIDTH-1:0]            in_value,
  input  logic [INDEX_WIDTH-1:0]                         in_index,
  output logic                                           ram_write_en,
  output logic [RAM_ADDRESS_WIDTH-1:0]                   ram_address,
  output logic [RAM_PARALLEL*SMALLEST_ELEMENT_WIDTH-1:0] ram_value,
  output logic [RAM_PARALLEL*INDEX_WIDTH-1:0]            ram_indices_value,
  output logic                                           busy,
  output logic                                           done,
  output logic                                           overflow
);

  localparam int VW     = RAM_PARALLEL * SMALLEST_ELEMENT_WIDTH;
  localparam int XW     = RAM_PARALLEL * INDEX_WIDTH;
  localparam int SLOT_W = $clog2(RAM_PARALLEL);
  localparam int RAW    = RAM_ADDRESS_WIDTH;

  pack_state_e       state_q, state_d;
  logic [1:0]        bw_q, bw_d;
  logic [VW-1:0]     count_q, count_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [RAW-1:0]    addr_q, addr_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              insert, flush, clear, slot_last, wrapped;
  int                per;

  logic              wr_valid;
  logic [RAW-1:0]    wr_addr;
  logic [VW-1:0]     wr_value;
  logic [XW-1:0]     wr_index;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      bw_q    <= '0;
      count_q <= '0;
      slot_q  <= '0;
      addr_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bw_q    <= bw_d;
      count_q <= count_d;
      slot_q  <= slot_d;
      addr_q  <= addr_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bw_d      = bw_q;
    count_d   = count_q;
    slot_d    = slot_q;
    addr_d    = addr_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    insert    = 1'b0;
    flush     = 1'b0;
    clear     = 1'b0;
    per       = elems_per_word(bw_q, RAM_PARALLEL, SMALLEST_ELEMENT_WIDTH);
    slot_last = (int'(slot_q) == per - 1);
    // Address 0 belongs to the header; reaching it again means the RAM is full.
    wrapped   = (addr_q == '0);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FILL;
          bw_d    = norm_bw(bitwidth);
          count_d = '0;
          slot_d  = '0;
          addr_d  = RAW'(1);
          ovf_d   = 1'b0;
          clear   = 1'b1;
        end
      end
      ST_FILL: begin
        if (in_valid) begin
          if (wrapped) begin
            ovf_d = 1'b1;
          end else begin
            insert = 1'b1;
            if (count_q != '1) count_d = count_q + VW'(1);
            if (slot_last) begin
              flush  = 1'b1;
              slot_d = '0;
              addr_d = addr_q + RAW'(1);
            end else begin
              slot_d = slot_q + SLOT_W'(1);
            end
          end
        end
        if (finish) begin
          if (!flush && (slot_q != '0 || insert)) begin
            flush  = 1'b1;
            slot_d = '0;
            addr_d = addr_q + RAW'(1);
          end
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN:  state_d = ST_HEADER;
      ST_HEADER: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  ram_word_assembler #(
    .RAM_ADDRESS_WIDTH      (RAM_ADDRESS_WIDTH),
    .RAM_PARALLEL           (RAM_PARALLEL),
    .INDEX_WIDTH            (INDEX_WIDTH),
    .SMALLEST_ELEMENT_WIDTH (SMALLEST_ELEMENT_WIDTH)
  ) u_asm (
    .clk        (clk),
    .reset_n    (reset_n),
    .bw_i       (bw_q),
    .insert_i   (insert),
    .slot_i     (slot_q),
    .value_i    (in_value),
    .index_i    (in_index),
    .flush_i    (flush),
    .clear_i    (clear),
    .addr_i     (addr_q),
    .wr_valid_o (wr_valid),
    .wr_addr_o  (wr_addr),
    .wr_value_o (wr_value),
    .wr_index_o (wr_index)
  );

  // The pending data word always drains before HEADER, so the two never collide.
  always_comb begin
    ram_write_en      = 1'b0;
    ram_address       = '0;
    ram_value         = '0;
    ram_indices_value = '0;
    if (wr_valid) begin
      ram_write_en      = 1'b1;
      ram_address       = wr_addr;
      ram_value         = wr_value;
      ram_indices_value = wr_index;
    end else if (state_q == ST_HEADER) begin
      ram_write_en = 1'b1;
      ram_value    = count_q;
    end
  end

  assign in_ready = (state_q == ST_FILL);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule
